// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline-control definitions: stall bus type, stage indices,
// merged stall masks and controller FSM encodings.
package pipeline_ctrl_pkg;

  typedef logic [5:0] STALL_BUS;

  localparam int STAGE_PC  = 0;
  localparam int STAGE_IF  = 1;
  localparam int STAGE_ID  = 2;
  localparam int STAGE_EX  = 3;
  localparam int STAGE_MEM = 4;
  localparam int STAGE_WB  = 5;

  // A stalling stage freezes itself and every stage upstream of it.
  localparam STALL_BUS STALL_MASK_MEM = 6'b011111;
  localparam STALL_BUS STALL_MASK_EX  = 6'b001111;
  localparam STALL_BUS STALL_MASK_ID  = 6'b000111;

  typedef enum logic [1:0] {
    CTRL_RUN   = 2'd0,
    CTRL_PEND  = 2'd1,
    CTRL_FLUSH = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/pipeline_ctrl_stall_timer.sv
// Saturating stall watchdog: counts enabled cycles up to TIMEOUT and raises a
// registered terminal flag that stays high until the counter is cleared.
module stall_timer #(
  parameter int TIMEOUT = 1023,
  parameter int W       = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam logic [W-1:0] MAX = W'(TIMEOUT);

  logic [W-1:0] cnt_q, cnt_d;
  logic         expired_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != MAX))
      cnt_d = cnt_q + 1'b1;
  end

  // Flag is registered from the next count so it rises on the same edge the
  // counter reaches MAX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= (cnt_d == MAX);
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: merges stage stall requests, defers
// exception flushes past MEM stalls, and runs the stall watchdog.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int STALL_TIMEOUT = 1023,
  parameter int TMR_W         = $clog2(STALL_TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_req_id,
  input  logic        stall_req_ex,
  input  logic        stall_req_mem,
  input  logic        exc_req,
  input  logic [31:0] exc_addr,
  output STALL_BUS    stall,
  output logic        flush,
  output logic [31:0] flush_pc,
  output logic        timeout,
  output logic        busy
);

  ctrl_state_e state_q, state_d;
  logic [31:0] flush_pc_q, flush_pc_d;
  STALL_BUS    stall_raw;

  always_comb begin
    stall_raw = '0;
    if (stall_req_mem)
      stall_raw = STALL_MASK_MEM;
    else if (stall_req_ex)
      stall_raw = STALL_MASK_EX;
    else if (stall_req_id)
      stall_raw = STALL_MASK_ID;
  end

  assign stall = (state_q == CTRL_FLUSH) ? '0 : stall_raw;

  // Only RUN accepts an exception; the first one captured owns flush_pc.
  always_comb begin
    state_d    = state_q;
    flush_pc_d = flush_pc_q;
    case (state_q)
      CTRL_RUN: begin
        if (exc_req) begin
          flush_pc_d = exc_addr;
          state_d    = stall_req_mem ? CTRL_PEND : CTRL_FLUSH;
        end
      end
      CTRL_PEND:  if (!stall_req_mem) state_d = CTRL_FLUSH;
      CTRL_FLUSH: state_d = CTRL_RUN;
      default:    state_d = CTRL_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= CTRL_RUN;
      flush_pc_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      flush_pc_q <= flush_pc_d;
    end
  end

  assign flush    = (state_q == CTRL_FLUSH);
  assign busy     = (state_q != CTRL_RUN);
  assign flush_pc = flush_pc_q;

  stall_timer #(
    .TIMEOUT (STALL_TIMEOUT),
    .W       (TMR_W)
  ) u_stall_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     ((stall == '0) || (state_q == CTRL_FLUSH)),
    .inc_i     (stall != '0),
    .expired_o (timeout)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with a 4-cycle watchdog; inputs change
// 1ns after the rising edge, outputs are sampled on the falling edge.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_req_id, stall_req_ex, stall_req_mem;
  logic        exc_req;
  logic [31:0] exc_addr;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        timeout;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.STALL_TIMEOUT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_req_id  (stall_req_id),
    .stall_req_ex  (stall_req_ex),
    .stall_req_mem (stall_req_mem),
    .exc_req       (exc_req),
    .exc_addr      (exc_addr),
    .stall         (stall),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .timeout       (timeout),
    .busy          (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_in(input logic id, input logic ex, input logic mem,
                        input logic exc, input logic [31:0] addr);
    stall_req_id  = id;
    stall_req_ex  = ex;
    stall_req_mem = mem;
    exc_req       = exc;
    exc_addr      = addr;
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 32'h0);
    tick();
    smp();
    chk("rst_flush", {31'b0, flush}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_pc", flush_pc, 32'h0);
    chk("rst_timeout", {31'b0, timeout}, 32'd0);
    chk("rst_stall", {26'b0, stall}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Stall priority, three consecutive stalled cycles.
    set_in(1, 0, 0, 0, 32'h0); smp();
    chk("prio_id", {26'b0, stall}, 32'h07);
    tick(); set_in(1, 1, 0, 0, 32'h0); smp();
    chk("prio_ex", {26'b0, stall}, 32'h0F);
    tick(); set_in(1, 1, 1, 0, 32'h0); smp();
    chk("prio_mem", {26'b0, stall}, 32'h1F);
    chk("wd3_during", {31'b0, timeout}, 32'd0);
    tick(); set_in(0, 0, 0, 0, 32'h0); smp();
    chk("wd3_after", {31'b0, timeout}, 32'd0);
    chk("idle_stall", {26'b0, stall}, 32'd0);
    tick();

    // Exception with MEM idle.
    set_in(0, 0, 0, 1, 32'hBFC00380); smp();
    chk("exc_n_flush", {31'b0, flush}, 32'd0);
    chk("exc_n_busy", {31'b0, busy}, 32'd0);
    tick(); set_in(1, 0, 0, 0, 32'h0); smp();
    chk("exc_flush", {31'b0, flush}, 32'd1);
    chk("exc_pc", flush_pc, 32'hBFC00380);
    chk("exc_busy", {31'b0, busy}, 32'd1);
    chk("exc_stall0", {26'b0, stall}, 32'd0);
    tick(); set_in(0, 0, 0, 0, 32'h0); smp();
    chk("exc_done_flush", {31'b0, flush}, 32'd0);
    chk("exc_done_busy", {31'b0, busy}, 32'd0);
    tick();

    // Exception during MEM stall, second exception ignored.
    for (int c = 0; c <= 12; c++) begin
      set_in(0, 0, (c >= 3 && c <= 9), (c == 4 || c == 6),
             (c == 4) ? 32'h80000180 : 32'h00001234);
      smp();
      chk($sformatf("pend_flush_c%0d", c), {31'b0, flush}, {31'b0, c == 11});
      chk($sformatf("pend_busy_c%0d", c), {31'b0, busy}, {31'b0, (c >= 5 && c <= 11)});
      if (c >= 5 && c <= 11)
        chk($sformatf("pend_pc_c%0d", c), flush_pc, 32'h80000180);
      tick();
    end
    set_in(0, 0, 0, 0, 32'h0);
    tick(); tick();

    // Watchdog: ex held for cycles 0..9.
    for (int c = 0; c <= 11; c++) begin
      set_in(0, (c <= 9), 0, 0, 32'h0);
      smp();
      chk($sformatf("wd_to_c%0d", c), {31'b0, timeout}, {31'b0, (c >= 4 && c <= 10)});
      chk($sformatf("wd_stall_c%0d", c), {26'b0, stall}, (c <= 9) ? 32'h0F : 32'h0);
      tick();
    end

    // Reset while in PEND.
    set_in(0, 0, 1, 1, 32'hDEADBEEF); smp();
    tick(); set_in(0, 0, 1, 0, 32'h0); smp();
    chk("pre_rst_busy", {31'b0, busy}, 32'd1);
    chk("pre_rst_pc", flush_pc, 32'hDEADBEEF);
    rst = 1'b1;
    #1;
    chk("arst_flush", {31'b0, flush}, 32'd0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_pc", flush_pc, 32'h0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      set_in(0, 0, (c == 0), 0, 32'h0);
      smp();
      chk($sformatf("post_rst_flush_c%0d", c), {31'b0, flush}, 32'd0);
      chk($sformatf("post_rst_busy_c%0d", c), {31'b0, busy}, 32'd0);
      tick();
    end

    // exc_req in the RUN cycle where MEM stall has just dropped.
    set_in(0, 0, 1, 0, 32'h0); smp();
    tick(); set_in(0, 0, 0, 1, 32'h00000100); smp();
    chk("fall_n_flush", {31'b0, flush}, 32'd0);
    tick(); set_in(0, 0, 0, 0, 32'h0); smp();
    chk("fall_flush", {31'b0, flush}, 32'd1);
    chk("fall_pc", flush_pc, 32'h00000100);
    tick(); smp();
    chk("fall_done", {31'b0, flush}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
